// File: rtl/adder_sum_accumulator_pkg.sv
// Shared types and constants for the adder result accumulator.
package adder_sum_accumulator_pkg;

  localparam int N_DEFAULT = 64;
  // A beat is the upstream sum plus its carry-out.
  localparam int BEAT_W = N_DEFAULT + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/adder_sum_accumulator.sv
// Sums a batch of {cout, s} adder beats into a wide accumulator and presents
// total, beat count and sticky wrap flag on a valid/ready output.
module adder_sum_accumulator
  import adder_sum_accumulator_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int ACC_W = 80,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [CNT_W-1:0] batch_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_sum,
  input  logic             in_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  state_t           r_state;
  state_t           w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_len;
  logic             r_ovf;

  logic             w_accept;
  logic [ACC_W-1:0] w_beat;
  logic [ACC_W:0]   w_sum;
  logic [CNT_W-1:0] w_len_first;
  logic [CNT_W-1:0] w_count_inc;

  // in_ready is a pure state decode, gated by reset so it reads 0 while held.
  assign in_ready    = rst_n && (r_state != S_HOLD);
  assign w_accept    = in_valid && in_ready;
  assign w_beat      = ACC_W'({in_cout, in_sum});
  assign w_sum       = {1'b0, r_acc} + {1'b0, w_beat};
  assign w_len_first = (batch_len == '0) ? CNT_W'(1) : batch_len;
  assign w_count_inc = r_count + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_state_next = (w_len_first == CNT_W'(1)) ? S_HOLD : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_accept && (w_count_inc == r_len)) begin
            w_state_next = S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      r_acc   <= '0;
      r_count <= '0;
      r_len   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        // First beat of a batch latches the length; later changes are ignored.
        r_acc   <= w_beat;
        r_count <= CNT_W'(1);
        r_ovf   <= 1'b0;
        r_len   <= w_len_first;
      end else begin
        r_acc   <= w_sum[ACC_W-1:0];
        r_ovf   <= r_ovf | w_sum[ACC_W];
        r_count <= w_count_inc;
      end
    end
  end

  assign out_valid = (r_state == S_HOLD);
  assign out_acc   = r_acc;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Scoreboard bench: an 80-bit and a 65-bit accumulator share one stimulus stream.
module tb_adder_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [15:0] batch_len;
  logic        in_valid;
  logic [63:0] in_sum;
  logic        in_cout;
  logic        out_ready;

  logic        in_ready,  out_valid,  out_ovf;
  logic [79:0] out_acc;
  logic [15:0] out_count;
  logic        in_ready_b, out_valid_b, out_ovf_b;
  logic [64:0] out_acc_b;
  logic [15:0] out_count_b;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [79:0] acc;
    logic [79:0] acc65;
    logic [15:0] cnt;
    logic        ovf;
    logic        ovf65;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always #5 clk = ~clk;

  adder_sum_accumulator #(.N(64), .ACC_W(80), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .batch_len(batch_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_cout(in_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  adder_sum_accumulator #(.N(64), .ACC_W(65), .CNT_W(16)) dut65 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .batch_len(batch_len),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_sum(in_sum), .in_cout(in_cout),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b),
    .out_count(out_count_b), .out_ovf(out_ovf_b)
  );

  // Scoreboard: pop one expected result per completed output handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_result acc=%h count=%0d ovf=%b required=no result", out_acc, out_count, out_ovf);
      end else begin
        e = sb.pop_front();
        if ({out_acc, out_count, out_ovf} !== {e.acc, e.cnt, e.ovf}) begin
          n_bad++;
          $display("FAIL result80 got acc=%h cnt=%0d ovf=%b required acc=%h cnt=%0d ovf=%b",
                   out_acc, out_count, out_ovf, e.acc, e.cnt, e.ovf);
        end else
          $display("result80 acc=%h cnt=%0d ovf=%b ok", out_acc, out_count, out_ovf);
        n_cmp++;
        if ({out_valid_b, 15'd0, out_acc_b, out_count_b, out_ovf_b} !== {1'b1, e.acc65, e.cnt, e.ovf65}) begin
          n_bad++;
          $display("FAIL result65 got v=%b acc=%h cnt=%0d ovf=%b required v=1 acc=%h cnt=%0d ovf=%b",
                   out_valid_b, out_acc_b, out_count_b, out_ovf_b, e.acc65, e.cnt, e.ovf65);
        end else
          $display("result65 acc=%h cnt=%0d ovf=%b ok", out_acc_b, out_count_b, out_ovf_b);
      end
    end
  end

  // Present one beat, wait (bounded) for in_ready, hold it through the accepting edge.
  task automatic send(input logic [63:0] s, input logic c, output int waited);
    waited = 0;
    in_valid = 1'b1;
    in_sum   = s;
    in_cout  = c;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("beat sum=%h cout=%b waited=%0d", s, c, waited);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; batch_len = '0; in_valid = 1'b1;
    in_sum = '0; in_cout = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b00) begin
        n_bad++;
        $display("FAIL reset_hold cycle=%0d in_ready=%b out_valid=%b required 0 0", i, in_ready, out_valid);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_acc, out_count, out_ovf} !== {1'b1, 1'b0, 80'd0, 16'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_release in_ready=%b out_valid=%b acc=%h cnt=%0d ovf=%b required 1 0 0 0 0",
               in_ready, out_valid, out_acc, out_count, out_ovf);
    end
    $display("reset done");
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int w;
    batch_len = 16'd0;
    sb.push_back('{80'h1_FFFF_FFFF_FFFF_FFFF, 80'h1_FFFF_FFFF_FFFF_FFFF, 16'd1, 1'b0, 1'b0});
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, w);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_bad++;
      $display("FAIL single_latency out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_drain pending=%0d out_valid=%b required 0 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int w, wsum;
    wsum = 0;
    batch_len = 16'd4;
    sb.push_back('{80'd10, 80'd10, 16'd4, 1'b0, 1'b0});
    for (int i = 1; i <= 4; i++) begin
      send(64'(i), 1'b0, w);
      wsum += w;
      batch_len = 16'd1;
      if (i < 4) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_early beat=%0d out_valid=%b required 0", i, out_valid);
        end
      end
    end
    n_cmp++;
    if (out_valid !== 1'b1 || wsum != 0) begin
      n_bad++;
      $display("FAIL b2b_timing out_valid=%b stalls=%0d required 1 0", out_valid, wsum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int w;
    batch_len = 16'd2;
    sb.push_back('{80'd3, 80'd3, 16'd2, 1'b0, 1'b0});
    sb.push_back('{80'd7, 80'd7, 16'd1, 1'b0, 1'b0});
    out_ready = 1'b0;
    send(64'd1, 1'b0, w);
    send(64'd2, 1'b0, w);
    batch_len = 16'd1;
    in_valid = 1'b1; in_sum = 64'd7; in_cout = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({in_ready, out_valid, out_acc, out_count} !== {1'b0, 1'b1, 80'd3, 16'd2}) begin
        n_bad++;
        $display("FAIL hold_stable cycle=%0d in_ready=%b out_valid=%b acc=%h cnt=%0d required 0 1 3 2",
                 i, in_ready, out_valid, out_acc, out_count);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL hold_release in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL post_hold_accept out_valid=%b required 1", out_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL backpressure_drain pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_overflow();
    int w;
    batch_len = 16'd2;
    sb.push_back('{80'h3_FFFF_FFFF_FFFF_FFFE, 80'h1_FFFF_FFFF_FFFF_FFFE, 16'd2, 1'b0, 1'b1});
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, w);
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, w);
    @(posedge clk); #1;
    batch_len = 16'd1;
    sb.push_back('{80'd5, 80'd5, 16'd1, 1'b0, 1'b0});
    send(64'd5, 1'b0, w);
    @(posedge clk); #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL overflow_drain pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_clear();
    int w;
    batch_len = 16'd3;
    send(64'd1, 1'b0, w);
    send(64'd2, 1'b0, w);
    in_valid = 1'b1; in_sum = 64'd3; in_cout = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; clear = 1'b0;
    n_cmp++;
    if ({out_valid, out_acc, out_count, out_ovf} !== {1'b0, 80'd0, 16'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL clear_last_beat out_valid=%b acc=%h cnt=%0d ovf=%b required 0 0 0 0",
               out_valid, out_acc, out_count, out_ovf);
    end
    $display("clear applied on final beat");
    repeat (3) @(posedge clk);
    #1;
    batch_len = 16'd2;
    sb.push_back('{80'd11, 80'd11, 16'd2, 1'b0, 1'b0});
    send(64'd5, 1'b0, w);
    send(64'd6, 1'b0, w);
    @(posedge clk); #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL clear_followup_drain pending=%0d required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_clear();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_sum_accumulator.md
Name: adder_sum_accumulator

Overview:
Downstream consumer of the N-bit ripple-carry adder stage. Accepts {cout, s} result beats over a valid/ready handshake and sums a batch of them into a wide accumulator. Presents the batch total, beat count and a sticky overflow flag on an output valid/ready handshake. Used for multi-operand sums and adder throughput checks.

Parameters:
N, 64, width of the upstream sum bus (excluding carry)
ACC_W, 80, accumulator width; must be >= N+1
CNT_W, 16, width of batch length and beat counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous abort; returns block to IDLE, highest priority
batch_len  input  CNT_W  beats per batch; sampled on the first accepted beat; 0 treated as 1
in_valid  input  1  upstream result beat valid
in_ready  output  1  block can accept a beat
in_sum  input  N  upstream sum s
in_cout  input  1  upstream carry-out
out_valid  output  1  batch result valid
out_ready  input  1  downstream accepts result
out_acc  output  ACC_W  accumulated total
out_count  output  CNT_W  beats accumulated in this batch
out_ovf  output  1  sticky: accumulator wrapped during this batch

Behaviour:
- Reset (rst_n low, async): state=IDLE; acc, count, len_q, ovf all 0. Outputs: in_ready=0 while rst_n low, 1 in the first cycle after release; out_valid=0, out_acc=0, out_count=0, out_ovf=0.
- Beat value = zero-extension of {in_cout, in_sum} (N+1 bits) to ACC_W. Accept = in_valid & in_ready.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On accept: acc<=beat, count<=1, ovf<=0, len_q<=max(batch_len,1). If len_q==1 go to HOLD, else go to ACCUM.
  - ACCUM: in_ready=1. On accept: {c,acc}<=acc+beat (ACC_W+1-bit sum), ovf<=ovf|c, count<=count+1. When the new count==len_q go to HOLD.
  - HOLD: in_ready=0, out_valid=1; out_acc, out_count and out_ovf are stable. On out_ready go to IDLE. Registers keep their values until the next first beat.
- Latency: out_valid rises the cycle after the final beat is accepted. Sustained throughput is one beat per cycle within a batch, with one HOLD cycle minimum between batches.
- in_ready is a registered-state decode only and never depends on out_ready combinationally. No acceptance in HOLD.
- Wrap-around: the accumulator is modulo 2^ACC_W and ovf is sticky for the batch. count cannot wrap because len_q <= 2^CNT_W-1.
- batch_len changes after the first beat are ignored.
- clear: next state IDLE; acc, count, ovf zeroed; any beat presented in that cycle is dropped (in_ready stays as decoded, but the accept has no effect); out_valid is 0 the following cycle. clear during HOLD discards the result.
- clear and the last beat in the same cycle: clear wins, and no out_valid is produced.
- rst_n assertion mid-batch: immediate return to reset values; the partial batch is lost.
- out_* are registered; no combinational path from in_* to out_*.

Decomposition:
- Shared package: state enum (IDLE, ACCUM, HOLD) and the constant BEAT_W = N+1.
- No sub-module required. The accumulator add uses a behavioural ACC_W+1-bit add.
- Optional: a fullAdder-chain accumulator variant is allowed only under a separate parameter. Not in scope here.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_valid=0 throughout; out_acc=0 after release.
- Single beat, batch_len=0: in_sum=64'hFFFF_FFFF_FFFF_FFFF, in_cout=1 -> next cycle out_valid=1, out_acc=80'h1_FFFF_FFFF_FFFF_FFFF, out_count=1, out_ovf=0.
- Batch of 4 back-to-back beats 1,2,3,4 (cout=0), batch_len=4 -> out_acc=10, out_count=4, with out_valid on the cycle after the 4th accept.
- Backpressure: out_ready=0 for 5 cycles in HOLD with in_valid=1 -> in_ready=0, output stable; then out_ready=1 -> IDLE, and the next beat is accepted the following cycle.
- Overflow, ACC_W=65: two beats of {1,64'hFFFF_FFFF_FFFF_FFFF} -> out_acc=65'h1_FFFF_FFFF_FFFF_FFFE, out_ovf=1; the next batch starts with out_ovf cleared.
- clear on the 3rd beat of a batch_len=3 batch -> no out_valid; the following batch of beats 5,6 (batch_len=2) -> out_acc=11.
